// File: rtl/sum_accum.sv
// Frame accumulator: sums a run of upstream adder results (len words per frame)
// and holds the modulo-2^ACC_W total plus a sticky overflow flag until it is taken downstream.
module sum_accum #(
    parameter int N     = 4,
    parameter int ACC_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N:0]       in_sum,
    output logic             in_ready,
    input  logic [LEN_W-1:0] len,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;

    logic               in_xfer_s;
    logic               out_xfer_s;
    logic [ACC_W-1:0]   sum_ext_s;
    logic [ACC_W:0]     add_s;
    logic [LEN_W-1:0]   cnt_inc_s;
    logic [LEN_W-1:0]   len_eff_s;

    // Unsigned add returning {carry_out, sum} so the carry feeds the sticky overflow.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        add_carry = {1'b0, a} + {1'b0, b};
    endfunction

    assign in_ready   = (state_q != HOLD);
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign out_acc    = acc_q;
    assign out_ovf    = ovf_q;

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;
    assign sum_ext_s  = ACC_W'(in_sum);
    assign add_s      = add_carry(acc_q, sum_ext_s);
    assign cnt_inc_s  = cnt_q + LEN_W'(1);
    // A zero length is treated as a single-word frame.
    assign len_eff_s  = (len == LEN_W'(0)) ? LEN_W'(1) : len;

    // Next-state and datapath update for the IDLE/ACC/HOLD handshake machine.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_xfer_s) begin
                    len_d = len_eff_s;
                    acc_d = sum_ext_s;
                    cnt_d = LEN_W'(1);
                    ovf_d = 1'b0;
                    if (len_eff_s == LEN_W'(1)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (in_xfer_s) begin
                    acc_d = add_s[ACC_W-1:0];
                    ovf_d = ovf_q | add_s[ACC_W];
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == len_q) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            HOLD: begin
                if (out_xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = ACC_W'(0);
                cnt_d   = LEN_W'(0);
                len_d   = LEN_W'(0);
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= ACC_W'(0);
            cnt_q   <= LEN_W'(0);
            len_q   <= LEN_W'(0);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum (N=4, ACC_W=8, LEN_W=4).
module tb_sum_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_sum;
    logic       in_ready;
    logic [3:0] len;
    logic       out_valid;
    logic [7:0] out_acc;
    logic       out_ovf;
    logic       out_ready;
    logic       busy;

    int vectors;
    int miscompares;

    sum_accum #(.N(4), .ACC_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .len       (len),
        .out_valid (out_valid),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [3:0] l,
                         input logic ordy);
        in_valid  = v;
        in_sum    = s;
        len       = l;
        out_ready = ordy;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [7:0] acc, input logic ovf);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_acc"},   32'(out_acc),   32'(acc));
        chk({tag, "_out_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_out_acc", 32'(out_acc), 32'd0);
        chk("reset_out_ovf", 32'(out_ovf), 32'd0);

        // len=3, sums 5,10,31
        drive(1'b1, 5'd5, 4'd3, 1'b1);
        tick();
        chk("f1_busy_acc", 32'(busy), 32'd1);
        chk("f1_ov_early", 32'(out_valid), 32'd0);
        drive(1'b1, 5'd10, 4'd3, 1'b1);
        tick();
        chk("f1_ov_early2", 32'(out_valid), 32'd0);
        drive(1'b1, 5'd31, 4'd3, 1'b1);
        tick();
        chk_hold("f1", 8'd46, 1'b0);
        drive(1'b0, 5'd0, 4'd3, 1'b1);
        tick();
        chk_idle("f1_done");

        // len=0 treated as 1
        drive(1'b1, 5'd17, 4'd0, 1'b1);
        tick();
        chk_hold("f2", 8'd17, 1'b0);
        drive(1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk_idle("f2_done");

        // len=10, ten sums of 31 -> 310 mod 256 = 54, overflow
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'd31, 4'd10, 1'b1);
            tick();
            if (i == 8) chk("f3_ov_early", 32'(out_valid), 32'd0);
        end
        chk_hold("f3", 8'd54, 1'b1);
        drive(1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk_idle("f3_done");

        // len=1 sum 2 clears overflow; then downstream stalls for 5 cycles
        drive(1'b1, 5'd2, 4'd1, 1'b0);
        tick();
        chk_hold("f4", 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd9, 4'd1, 1'b0);
            tick();
            chk_hold("f4_stall", 8'd2, 1'b0);
        end
        // Output transfer with in_valid high: must not start a new frame this cycle
        drive(1'b1, 5'd9, 4'd1, 1'b1);
        tick();
        chk_idle("f4_done");
        chk("f4_no_accum", 32'(out_acc), 32'd2);
        drive(1'b1, 5'd9, 4'd1, 1'b1);
        tick();
        chk_hold("f5", 8'd9, 1'b0);
        drive(1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk_idle("f5_done");

        // len=4 with bubbles; len changed after start is ignored
        drive(1'b1, 5'd1, 4'd4, 1'b1);
        tick();
        drive(1'b0, 5'd31, 4'd1, 1'b1);
        tick();
        chk("f6_bubble1", 32'(out_valid), 32'd0);
        drive(1'b1, 5'd2, 4'd1, 1'b1);
        tick();
        chk("f6_len_ignored", 32'(out_valid), 32'd0);
        drive(1'b0, 5'd31, 4'd1, 1'b1);
        tick();
        drive(1'b0, 5'd31, 4'd1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 4'd1, 1'b1);
        tick();
        chk("f6_ov_early", 32'(out_valid), 32'd0);
        chk("f6_busy", 32'(busy), 32'd1);
        drive(1'b1, 5'd4, 4'd1, 1'b1);
        tick();
        chk_hold("f6", 8'd10, 1'b0);
        drive(1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk_idle("f6_done");

        // Reset mid-frame discards the partial frame
        drive(1'b1, 5'd20, 4'd4, 1'b1);
        tick();
        drive(1'b1, 5'd21, 4'd4, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 4'd4, 1'b1);
        tick();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_out_acc", 32'(out_acc), 32'd0);
        chk("rst_mid_out_ovf", 32'(out_ovf), 32'd0);
        tick();
        chk("rst_mid_no_out", 32'(out_valid), 32'd0);
        drive(1'b1, 5'd7, 4'd2, 1'b1);
        tick();
        chk("f7_ov_early", 32'(out_valid), 32'd0);
        drive(1'b1, 5'd8, 4'd2, 1'b1);
        tick();
        chk_hold("f7", 8'd15, 1'b0);
        drive(1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk_idle("f7_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
